// File: rtl/module_alu_operand_loader_pkg.sv
// Shared bit-width package for the ALU datapath and its operand loader.
// Holds the datapath widths, the opcode type and the loader FSM state encoding.
package pkg_bits;

    localparam int BITS_WIDTH = 8;
    localparam int OP_WIDTH   = 4;

    typedef logic [BITS_WIDTH-1:0] bits_t;
    typedef logic [BITS_WIDTH:0]   bitsw_t;
    typedef logic [OP_WIDTH-1:0]   op_t;

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'd0,
        S_WAIT_B  = 2'd1,
        S_WAIT_OP = 2'd2,
        S_VALID   = 2'd3
    } loader_state_t;

    // The opcode and its fill flag share one switch word: opcode low, flag just above it.
    function automatic op_t opcode_field(input bits_t word);
        return word[OP_WIDTH-1:0];
    endfunction

    function automatic logic flag_field(input bits_t word);
        return word[OP_WIDTH];
    endfunction

endpackage

// File: rtl/module_alu_operand_loader_if.sv
// Operand-loader bus: switch/button inputs plus the registered operand bundle and handshake.
// master = board/upstream side driving switches and ready, slave = the loader itself.
interface module_alu_operand_loader_if;
    import pkg_bits::*;

    bits_t       data_i;
    logic        load_i;
    logic        clear_i;
    logic        ready_i;
    bits_t       ALUA_o;
    bits_t       ALUB_o;
    op_t         ALUControl_o;
    logic        ALUFlagIn_o;
    logic        valid_o;
    logic [1:0]  stage_o;

    modport master (
        output data_i, load_i, clear_i, ready_i,
        input  ALUA_o, ALUB_o, ALUControl_o, ALUFlagIn_o, valid_o, stage_o
    );

    modport slave (
        input  data_i, load_i, clear_i, ready_i,
        output ALUA_o, ALUB_o, ALUControl_o, ALUFlagIn_o, valid_o, stage_o
    );

endinterface

// File: rtl/module_alu_operand_loader_debouncer.sv
// Button conditioner: 2-flop synchronizer followed by a stability counter.
// Everything resets high so a button held through reset never looks like a fresh press.
module module_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/module_alu_operand_loader.sv
// Operand loader: captures A, B, opcode+flag one per load press and offers them as a valid/ready bundle.
// Define ALU_LOADER_DEBOUNCE_EN to synchronize and debounce load_i; otherwise load_i is taken as clean.
module module_alu_operand_loader
    import pkg_bits::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    module_alu_operand_loader_if.slave    bus
);

    if (BITS_WIDTH < OP_WIDTH + 1) begin : g_width_check
        $error("BITS_WIDTH must be at least OP_WIDTH+1 to carry the opcode and flag");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    loader_state_t r_state;
    loader_state_t w_stateNext;
    bits_t         r_aluA;
    bits_t         r_aluB;
    op_t           r_aluOp;
    logic          r_aluFlag;
    logic          r_valid;
    logic          r_loadQ;
    logic          w_loadS;
    logic          w_loadEdge;
    logic          w_capA;
    logic          w_capB;
    logic          w_capOp;
    logic          w_clr;

`ifdef ALU_LOADER_DEBOUNCE_EN
    module_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_raw   (bus.load_i),
        .o_level (w_loadS)
    );
`else
    assign w_loadS = bus.load_i;
`endif

    // History resets high so a button already held at reset release gives no edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_loadQ <= 1'b1;
        end else begin
            r_loadQ <= w_loadS;
        end
    end

    assign w_loadEdge = w_loadS & ~r_loadQ;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_WAIT_A;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_valid <= (w_stateNext == S_VALID);
        end
    end

    // clear_i outranks both a load edge and a ready handshake in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_capA      = 1'b0;
        w_capB      = 1'b0;
        w_capOp     = 1'b0;
        w_clr       = 1'b0;
        if (bus.clear_i) begin
            w_stateNext = S_WAIT_A;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    if (w_loadEdge) begin
                        w_capA      = 1'b1;
                        w_stateNext = S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (w_loadEdge) begin
                        w_capB      = 1'b1;
                        w_stateNext = S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (w_loadEdge) begin
                        w_capOp     = 1'b1;
                        w_stateNext = S_VALID;
                    end
                end
                S_VALID: begin
                    if (r_valid && bus.ready_i) begin
                        w_stateNext = S_WAIT_A;
                    end
                end
                default: w_stateNext = S_WAIT_A;
            endcase
        end
    end

    // Fields only change on their own capture or a clear, so they hold through S_VALID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_aluOp   <= '0;
            r_aluFlag <= 1'b0;
        end else if (w_clr) begin
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_aluOp   <= '0;
            r_aluFlag <= 1'b0;
        end else begin
            if (w_capA) begin
                r_aluA <= bus.data_i;
            end
            if (w_capB) begin
                r_aluB <= bus.data_i;
            end
            if (w_capOp) begin
                r_aluOp   <= opcode_field(bus.data_i);
                r_aluFlag <= flag_field(bus.data_i);
            end
        end
    end

    assign bus.ALUA_o       = r_aluA;
    assign bus.ALUB_o       = r_aluB;
    assign bus.ALUControl_o = r_aluOp;
    assign bus.ALUFlagIn_o  = r_aluFlag;
    assign bus.valid_o      = r_valid;
    assign bus.stage_o      = r_state;

endmodule

// File: doc/module_alu_operand_loader.md
Name: module_alu_operand_loader

Overview:
- Upstream stage of the ALU datapath, including the right-shift unit.
- Captures operand A, operand B/shift amount, opcode and fill flag from the board switches, one field per press of a load button.
- Presents the captured fields as a stable, registered operand bundle with a valid/ready handshake to the ALU/result-register stage.
- Drives a stage indicator for the board LEDs.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable samples before a button level is accepted; used only with the optional feature.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset; asynchronous, active-high.
- data_i  input  BITS_WIDTH  switch bus.
- load_i  input  1  load button level.
- clear_i  input  1  synchronous abort, back to operand-A capture.
- ready_i  input  1  downstream accepts the bundle.
- ALUA_o  output  BITS_WIDTH  operand A; type bits_t.
- ALUB_o  output  BITS_WIDTH  operand B / shift amount; type bits_t.
- ALUControl_o  output  OP_WIDTH  opcode.
- ALUFlagIn_o  output  1  fill/carry-in flag.
- valid_o  output  1  bundle complete and stable.
- stage_o  output  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset: fixed as one clock, clk_i, with asynchronous active-high reset rst_i.
  - Reset state: FSM = S_WAIT_A.
  - All outputs 0: ALUA_o, ALUB_o, ALUControl_o, ALUFlagIn_o, valid_o; stage_o = 2'd0.
  - Edge-detect history register resets to 1, so a button already held at reset release is not captured.
- Edge detect: load_edge = load_s & ~load_q, where load_s is the conditioned button level. Exactly one capture per rising edge; holding the button does nothing further.
- FSM states and transitions; stage_o reflects the state in the same cycle:
  - S_WAIT_A (0): on load_edge, ALUA_o <= data_i, go to S_WAIT_B.
  - S_WAIT_B (1): on load_edge, ALUB_o <= data_i, go to S_WAIT_OP.
  - S_WAIT_OP (2): on load_edge, ALUControl_o <= data_i[OP_WIDTH-1:0], ALUFlagIn_o <= data_i[OP_WIDTH], go to S_VALID.
  - S_VALID (3): valid_o = 1 (registered; asserted the cycle after the third capture edge). When valid_o & ready_i are sampled high, go to S_WAIT_A; valid_o = 0 from the next cycle.
- Handshake:
  - Output fields are frozen while valid_o = 1.
  - load_edge in S_VALID is ignored.
  - ready_i outside S_VALID is ignored.
  - valid_o never drops without ready_i, except on clear_i or reset.
- Field retention: previous field values remain on the outputs until overwritten. There is no clearing on transaction completion.
- clear_i: from any state, next state = S_WAIT_A, valid_o = 0, all field outputs = 0. clear_i has priority over load_edge and ready_i in the same cycle.
- Reset mid-operation: immediate, same as the reset values above.
- Width rule: BITS_WIDTH >= OP_WIDTH+1 is required; violating it is an elaboration error (static assertion).
- Latency without the optional feature: a field is captured on the first clk_i edge at which load_i is seen high after being low.

Optional Feature:
- ALU_LOADER_DEBOUNCE_EN defined:
  - load_i passes through a 2-flop synchronizer and a debouncer.
  - The debouncer accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
  - Capture latency = 2 + DEBOUNCE_CYCLES cycles after a clean level change.
  - Glitches shorter than DEBOUNCE_CYCLES produce no capture.
- Undefined: load_i is treated as synchronous and clean; load_s = load_i, with no added latency.

Decomposition:
- Shared package pkg_bits:
  - existing BITS_WIDTH, bits_t and bitsw_t;
  - new OP_WIDTH = 4, op_t = logic [OP_WIDTH-1:0];
  - loader_state_t enum {S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_VALID} with explicit 2-bit encodings 0..3.
- One sub-module: module_debouncer (synchronizer + stability counter, parameter DEBOUNCE_CYCLES). Instantiated only under ALU_LOADER_DEBOUNCE_EN.

Test Plan (BITS_WIDTH=8, feature off unless stated):
- Reset then three load pulses with data_i = 8'hA5, 8'h03, 8'h19 -> ALUA_o=A5, ALUB_o=03, ALUControl_o=9, ALUFlagIn_o=1, valid_o=1, stage_o=3. ready_i=1 for one cycle -> valid_o=0, stage_o=0 next cycle.
- Load held high for 10 cycles in S_WAIT_A with data_i=8'h11 -> single capture, stage_o=1; changing data_i to 8'h22 while held -> ALUA_o stays 11.
- In S_VALID, ready_i=0 for 5 cycles, then toggle data_i and pulse load -> outputs and valid_o unchanged; stage_o stays 3.
- In S_WAIT_OP, assert clear_i and a load edge in the same cycle -> stage_o=0, all fields 0, no opcode capture.
- Assert rst_i asynchronously, mid-cycle, while in S_VALID -> valid_o=0 and fields 0 before the next clock edge. load_i held high at reset release -> no capture.
- ALU_LOADER_DEBOUNCE_EN with DEBOUNCE_CYCLES=4: 2-cycle glitch on load_i -> no capture. Clean press -> capture exactly 6 cycles after the rising edge.
